pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder; successor to the fixed 4-bit combinational CLA.
- Splits a WIDTH-bit add into BLOCK-bit lookahead groups, one group per pipeline stage.
- Carry ripples stage-to-stage through registers, so throughput is one add per cycle.
- Valid/ready handshakes on both sides; sits between operand producers and arithmetic result consumers in the datapath.

---
 rtl/cla_pkg.sv | 36 +++
 rtl/cla_group.sv | 37 +++
 rtl/pipelined_cla_adder.sv | 149 ++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types, limits and the lookahead carry function for the CLA pipeline
package cla_pkg;

   localparam int BLOCK_DEFAULT = 4;
   localparam int CLA_MAX_BLOCK = 32;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // Carry out of bit idx as a flat sum of products: g[j] & p[idx:j+1] terms plus cin & p[idx:0].
   function automatic logic cla_carry(input logic [CLA_MAX_BLOCK-1:0] g,
                                      input logic [CLA_MAX_BLOCK-1:0] p,
                                      input logic                     cin,
                                      input int                       idx);
      logic c;
      logic term;
      c = 1'b0;
      for (int j = 0; j < CLA_MAX_BLOCK; j++) begin
         if (j <= idx) begin
            term = g[j];
            for (int m = j + 1; m < CLA_MAX_BLOCK; m++) begin
               if (m <= idx) term = term & p[m];
            end
            c = c | term;
         end
      end
      term = cin;
      for (int m = 0; m < CLA_MAX_BLOCK; m++) begin
         if (m <= idx) term = term & p[m];
      end
      return c | term;
   endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational BLOCK-bit carry-lookahead group
module cla_group
   import cla_pkg::*;
#(
   parameter int BLOCK = BLOCK_DEFAULT
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             cout,
   output gp_t              gp,
   output logic             c_msb
);

   logic [CLA_MAX_BLOCK-1:0] g_pad;
   logic [CLA_MAX_BLOCK-1:0] p_pad;
   logic [BLOCK:0]           c;

   always_comb begin
      g_pad            = '0;
      p_pad            = '0;
      g_pad[BLOCK-1:0] = a & b;
      p_pad[BLOCK-1:0] = a ^ b;
      c                = '0;
      c[0]             = cin;
      for (int i = 0; i < BLOCK; i++) begin
         c[i+1] = cla_carry(g_pad, p_pad, cin, i);
      end
      sum   = p_pad[BLOCK-1:0] ^ c[BLOCK-1:0];
      cout  = c[BLOCK];
      c_msb = c[BLOCK-1];
      gp.g  = cla_carry(g_pad, p_pad, 1'b0, BLOCK - 1);
      gp.p  = &p_pad[BLOCK-1:0];
   end

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - skewed pipelined CLA adder, one lookahead group per stage
// PIPELINED_CLA_SUB_EN adds a sub input that turns the block into an adder/subtractor.
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int BLOCK = BLOCK_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef PIPELINED_CLA_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / BLOCK;

   if (WIDTH <= 0 || BLOCK <= 0 || BLOCK > CLA_MAX_BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
      $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK");
   end

   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
   logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
   logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
   logic [STAGES-1:0]            carry_q, carry_d;
   logic                         ovf_q, ovf_d;

   logic [STAGES:0]              ready;
   logic [STAGES-1:0]            valid_in;
   logic [STAGES-1:0]            cin_in;
   logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, sum_in;
   logic [WIDTH-1:0]             b_eff;
   logic                         cin_eff;

   logic [STAGES-1:0][BLOCK-1:0] grp_sum;
   gp_t  [STAGES-1:0]            grp_gp;
   logic [STAGES-1:0]            grp_cout;
   logic [STAGES-1:0]            grp_cmsb;
   logic                         unused_bits;

   always_comb begin
`ifdef PIPELINED_CLA_SUB_EN
      b_eff   = b ^ {WIDTH{sub}};
      cin_eff = cin ^ sub;
`else
      b_eff   = b;
      cin_eff = cin;
`endif
   end

   // Stage 0 sees the ports; every later stage sees the registers of the stage before it.
   always_comb begin
      valid_in[0] = in_valid;
      a_in[0]     = a;
      b_in[0]     = b_eff;
      sum_in[0]   = '0;
      cin_in[0]   = cin_eff;
      for (int k = 1; k < STAGES; k++) begin
         valid_in[k] = valid_q[k-1];
         a_in[k]     = a_q[k-1];
         b_in[k]     = b_q[k-1];
         sum_in[k]   = sum_q[k-1];
         cin_in[k]   = carry_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      cla_group #(.BLOCK(BLOCK)) u_group (
         .a     (a_in[k][k*BLOCK +: BLOCK]),
         .b     (b_in[k][k*BLOCK +: BLOCK]),
         .cin   (cin_in[k]),
         .sum   (grp_sum[k]),
         .cout  (grp_cout[k]),
         .gp    (grp_gp[k]),
         .c_msb (grp_cmsb[k])
      );
   end

   always_comb begin
      ready         = '0;
      ready[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         ready[k] = !valid_q[k] || ready[k+1];
      end
   end

   always_comb begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      for (int k = 0; k < STAGES; k++) begin
         if (ready[k]) begin
            valid_d[k] = valid_in[k];
            // Data registers only move for real operands, so bubbles leave the last result in place.
            if (valid_in[k]) begin
               a_d[k]                       = a_in[k];
               b_d[k]                       = b_in[k];
               sum_d[k]                     = sum_in[k];
               sum_d[k][k*BLOCK +: BLOCK]   = grp_sum[k];
               carry_d[k]                   = grp_gp[k].g | (grp_gp[k].p & cin_in[k]);
            end
         end
      end
      if (ready[STAGES-1] && valid_in[STAGES-1]) begin
         ovf_d = grp_cout[STAGES-1] ^ grp_cmsb[STAGES-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = ready[0];
   assign out_valid = valid_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = carry_q[STAGES-1];
   assign ovf       = ovf_q;

   assign unused_bits = ^{grp_cout, grp_cmsb, a_in, b_in, a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - self-checking bench for pipelined_cla_adder (WIDTH=16, BLOCK=4)
module tb_pipelined_cla_adder;

   localparam int WIDTH  = 16;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub_r;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int valid_cycles = 0;

   logic [17:0]      exp_q[$];
   logic [WIDTH-1:0] out_log[$];
   int               out_cyc[$];

   logic             stalled = 1'b0;
   logic [17:0]      held;

   pipelined_cla_adder #(.WIDTH(WIDTH), .BLOCK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef PIPELINED_CLA_SUB_EN
      .sub       (sub_r),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain integer addition on the effective operands; {ovf, cout, sum}.
   function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb_v,
                                         input logic tc, input logic ts);
      logic [15:0] bb;
      logic        cc;
      logic [16:0] full;
      logic        ov;
      bb   = tb_v ^ {16{ts}};
      cc   = tc ^ ts;
      full = {1'b0, ta} + {1'b0, bb} + {16'b0, cc};
      ov   = (ta[15] == bb[15]) && (full[15] != ta[15]);
      return {ov, full[16], full[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         stalled = 1'b0;
      end else begin
         if (out_valid) valid_cycles++;
         if (stalled) begin
            n_cmp++;
            if (!out_valid || {ovf, cout, sum} !== held) begin
               n_fail++;
               $display("FAIL stall_hold: got v=%0b %0h want v=1 %0h", out_valid, {ovf, cout, sum}, held);
            end
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output: got %0h want none", {ovf, cout, sum});
            end else begin
               held = exp_q.pop_front();
               if ({ovf, cout, sum} !== held) begin
                  n_fail++;
                  $display("FAIL model_result: got %0h want %0h", {ovf, cout, sum}, held);
               end
            end
            out_log.push_back(sum);
            out_cyc.push_back(cyc);
         end
         stalled = out_valid && !out_ready;
         held    = {ovf, cout, sum};
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub_r));
      end
   end

   task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc, input logic ts);
      bit ok;
      a = ta; b = tb_v; cin = tc; sub_r = ts; in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (exp_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      if (!ok) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   // Latency counts rising edges with the accepting edge as edge 1.
   task automatic expect_result(input string nm, input logic [15:0] es, input logic ec, input logic eo);
      int lat;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_latency"}, 32'(lat), 32'(STAGES));
      chk({nm, "_sum"}, 32'(sum), 32'(es));
      chk({nm, "_cout"}, 32'(cout), 32'(ec));
      chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
   endtask

   initial begin
      int base;
      int v0;
      bit  stall_seen;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub_r = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_sum", 32'(sum), 32'd0);
      chk("reset_cout", 32'(cout), 32'd0);
      chk("reset_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      expect_result("wrap", 16'h0000, 1'b1, 1'b0);
      wait_idle();
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      expect_result("sovf", 16'h8000, 1'b0, 1'b1);
      wait_idle();
      send(16'h1234, 16'h1234, 1'b1, 1'b0);
      expect_result("cin1", 16'h2469, 1'b0, 1'b0);
      wait_idle();

      base = out_log.size();
      stall_seen = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         #1;
         a = 16'(n); b = 16'(n); cin = 1'b0; sub_r = 1'b0; in_valid = 1'b1;
         @(negedge clk);
         if (!in_ready) stall_seen = 1'b1;
         @(posedge clk);
      end
      #1 in_valid = 1'b0;
      wait_idle();
      chk("b2b_in_ready", 32'(stall_seen), 32'd0);
      chk("b2b_count", 32'(out_log.size() - base), 32'd8);
      for (int i = 0; i < 8 && base + i < out_log.size(); i++) begin
         chk("b2b_sum", 32'(out_log[base+i]), 32'(2 * (i + 1)));
         chk("b2b_cycle", 32'(out_cyc[base+i] - out_cyc[base]), 32'(i));
      end

      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send(16'hF000 + 16'(i * 16'h0123), 16'h0F00 * 16'(i), 1'(i), 1'b0);
      a = 16'hABCD; b = 16'h5433; cin = 1'b1; sub_r = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_accept_on_release", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_idle();

      send(16'h0011, 16'h0022, 1'b0, 1'b0);
      send(16'h0033, 16'h0044, 1'b0, 1'b0);
      send(16'h0055, 16'h0066, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_sum", 32'(sum), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      v0 = valid_cycles;
      repeat (10) begin @(posedge clk); #1; end
      chk("midrst_no_stale", 32'(valid_cycles - v0), 32'd0);

`ifdef PIPELINED_CLA_SUB_EN
      send(16'h0005, 16'h0007, 1'b0, 1'b1);
      expect_result("sub_neg", 16'hFFFE, 1'b0, 1'b0);
      wait_idle();
      send(16'h8000, 16'h0001, 1'b0, 1'b1);
      expect_result("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
      wait_idle();
`endif

      wait_idle();
      chk("final_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
